// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Package   : wb_pkg
//  Purpose   : Shared Wishbone B4 definitions for the data-bus initiator and
//              responders: bus widths, responder state encoding and byte-lane
//              helper functions.
//  Revision  : 1.0  initial release
// ============================================================================
package wb_pkg;

  localparam int WB_DW     = 32;
  localparam int WB_SELW   = 4;
  localparam int WB_WAIT_W = 4;   // wait counter width, covers 0..15 wait states

  // Responder cycle state
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_t;

  // Per-lane write enables: a lane is written only when selected and the
  // access is an accepted write.
  function automatic logic [WB_SELW-1:0] lane_enables(
    input logic [WB_SELW-1:0] sel,
    input logic               en
  );
    return sel & {WB_SELW{en}};
  endfunction

  // Expand byte selects into a full data-width bit mask.
  function automatic logic [WB_DW-1:0] lane_mask(input logic [WB_SELW-1:0] sel);
    logic [WB_DW-1:0] m;
    m = '0;
    for (int b = 0; b < WB_SELW; b++) begin
      m[8*b +: 8] = {8{sel[b]}};
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_byte_ram.sv
`default_nettype none
// ============================================================================
//  Module    : wb_byte_ram
//  Purpose   : DEPTH_WORDS x 32 synchronous RAM with one write enable per byte
//              lane and a registered read port. The read register holds the
//              addressed word for exactly one cycle after a read strobe and is
//              zero otherwise, so it can drive a bus data output directly.
//  Revision  : 1.0  initial release
// ============================================================================
module wb_byte_ram
  import wb_pkg::*;
#(
  parameter int    DEPTH_WORDS = 64,
  parameter int    ADDR_W      = 6,
  parameter string INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [WB_SELW-1:0] byte_we,
  input  logic [WB_DW-1:0]   wdata,
  input  logic               rd_en,
  output logic [WB_DW-1:0]   rdata
);

  logic [WB_DW-1:0] mem [DEPTH_WORDS];

  // Byte-lane write: only lanes with an active enable are updated.
  always_ff @(posedge clk) begin
    for (int b = 0; b < WB_SELW; b++) begin
      if (byte_we[b]) begin
        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // Registered read port; returns to zero whenever no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (rd_en) begin
      rdata <= mem[addr];
    end else begin
      rdata <= '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module    : wb_dmem_responder
//  Purpose   : Wishbone B4 classic-cycle responder in front of the CPU data
//              RAM. Accepts single read/write cycles, inserts WAIT_STATES wait
//              cycles, applies byte-lane writes and terminates every accepted,
//              non-aborted cycle with exactly one ACK or ERR pulse.
//  Revision  : 1.0  initial release
// ============================================================================
module wb_dmem_responder
  import wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 64,
  parameter int          WAIT_STATES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [31:0]        wb_adr_i,
  input  logic [WB_DW-1:0]   wb_dat_i,
  input  logic [WB_SELW-1:0] wb_sel_i,
  output logic [WB_DW-1:0]   wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_err_o
);

  localparam int          ADDR_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN   = 33'(4 * DEPTH_WORDS);

  // FSM state and latched request
  wb_state_t              state;
  logic [WB_WAIT_W-1:0]   cnt;
  logic [31:0]            adr_q;
  logic [WB_DW-1:0]       dat_q;
  logic [WB_SELW-1:0]     sel_q;
  logic                   we_q;

  // Request view used for decode and RAM access
  logic [31:0]            req_adr;
  logic [WB_DW-1:0]       req_dat;
  logic [WB_SELW-1:0]     req_sel;
  logic                   req_we;
  logic [32:0]            offset;
  logic                   in_range;
  logic                   addr_ok;
  logic                   fire;
  logic [ADDR_W-1:0]      ram_addr;
  logic [WB_SELW-1:0]     ram_byte_we;
  logic                   ram_rd_en;

  // In IDLE the live bus is the request (needed for zero wait states);
  // afterwards the latched copy is used so mid-cycle bus changes are ignored.
  always_comb begin
    req_adr = adr_q;
    req_dat = dat_q;
    req_sel = sel_q;
    req_we  = we_q;
    if (state == IDLE) begin
      req_adr = wb_adr_i;
      req_dat = wb_dat_i;
      req_sel = wb_sel_i;
      req_we  = wb_we_i;
    end
  end

  // Address decode: inside the window and word-aligned. The offset is formed
  // with a carry bit so a window touching the top of the map cannot wrap.
  always_comb begin
    offset   = {1'b0, req_adr} - {1'b0, BASE_ADDR};
    in_range = (req_adr >= BASE_ADDR) && (offset < SPAN);
    addr_ok  = in_range && (req_adr[1:0] == 2'b00);
    ram_addr = offset[ADDR_W+1:2];
  end

  // fire marks the edge that enters RESP; the RAM access happens on that
  // edge so data and ACK appear together. Reset suppresses the access.
  always_comb begin
    fire = 1'b0;
    if (!reset) begin
      if (state == IDLE) begin
        fire = wb_cyc_i && wb_stb_i && (WAIT_STATES == 0);
      end else if (state == WAIT) begin
        fire = wb_cyc_i && (cnt == WB_WAIT_W'(1));
      end
    end
    ram_byte_we = lane_enables(req_sel, fire && addr_ok && req_we);
    ram_rd_en   = fire && addr_ok && !req_we;
  end

  wb_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W),
    .INIT_FILE   (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .addr    (ram_addr),
    .byte_we (ram_byte_we),
    .wdata   (req_dat),
    .rd_en   (ram_rd_en),
    .rdata   (wb_dat_o)
  );

  // Cycle FSM with registered ACK/ERR; a cycle is always followed by IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            adr_q <= wb_adr_i;
            dat_q <= wb_dat_i;
            sel_q <= wb_sel_i;
            we_q  <= wb_we_i;
            cnt   <= WB_WAIT_W'(WAIT_STATES);
            if (WAIT_STATES == 0) begin
              state    <= RESP;
              wb_ack_o <= addr_ok;
              wb_err_o <= !addr_ok;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            // Initiator abandoned the cycle: no write, no termination
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == WB_WAIT_W'(1)) begin
            state    <= RESP;
            cnt      <= '0;
            wb_ack_o <= addr_ok;
            wb_err_o <= !addr_ok;
          end else begin
            cnt <= cnt - WB_WAIT_W'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_wb_dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module    : tb_wb_dmem_responder
//  Purpose   : Directed self-checking bench. Two responders share one bus:
//              dut (WAIT_STATES=1) and dut0 (WAIT_STATES=0).
//  Revision  : 1.0  initial release
// ============================================================================
module tb_wb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        cyc, stb, we;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic [31:0] dat1, dat0;
  logic        ack1, err1, ack0, err0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  wb_dmem_responder #(
    .BASE_ADDR   (32'h0),
    .DEPTH_WORDS (64),
    .WAIT_STATES (1),
    .INIT_FILE   ("")
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_sel_i (sel),
    .wb_dat_o (dat1),
    .wb_ack_o (ack1),
    .wb_err_o (err1)
  );

  wb_dmem_responder #(
    .BASE_ADDR   (32'h0),
    .DEPTH_WORDS (64),
    .WAIT_STATES (0),
    .INIT_FILE   ("")
  ) dut0 (
    .clk      (clk),
    .reset    (reset),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_adr_i (adr),
    .wb_dat_i (wdat),
    .wb_sel_i (sel),
    .wb_dat_o (dat0),
    .wb_ack_o (ack0),
    .wb_err_o (err0)
  );

  // Bus driver: one classic cycle, returns cycles-to-termination (-1 on timeout)
  task automatic bus_xfer(input bit use0, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic ackv, output logic errv,
                          output logic [31:0] datv);
    logic at, et;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d; sel = s;
    lat = -1; ackv = 1'b0; errv = 1'b0; datv = '0;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk);
      @(negedge clk);
      at = use0 ? ack0 : ack1;
      et = use0 ? err0 : err1;
      if (at || et) begin
        lat = k; ackv = at; errv = et; datv = use0 ? dat0 : dat1;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc = 0; stb = 0; we = 0; adr = 0; wdat = 0; sel = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if (ack1 !== 1'b0) $display("FAIL reset_ack got=%b exp=0", ack1); else pass_cnt++;
    total_cnt++; if (err1 !== 1'b0) $display("FAIL reset_err got=%b exp=0", err1); else pass_cnt++;
    total_cnt++; if (dat1 !== 32'h0) $display("FAIL reset_dat got=%h exp=0", dat1); else pass_cnt++;
    total_cnt++; if (ack0 !== 1'b0) $display("FAIL reset_ack0 got=%b exp=0", ack0); else pass_cnt++;
    reset = 1'b0;
  endtask

  task automatic test_full_word();
    int l; logic a, e; logic [31:0] d;
    bus_xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, l, a, e, d);
    total_cnt++; if (l !== 2) $display("FAIL wr_latency got=%0d exp=2", l); else pass_cnt++;
    total_cnt++; if (a !== 1'b1 || e !== 1'b0) $display("FAIL wr_ack got=%b%b exp=10", a, e); else pass_cnt++;
    bus_xfer(0, 0, 32'h10, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (l !== 2) $display("FAIL rd_latency got=%0d exp=2", l); else pass_cnt++;
    total_cnt++; if (a !== 1'b1 || e !== 1'b0) $display("FAIL rd_ack got=%b%b exp=10", a, e); else pass_cnt++;
    total_cnt++; if (d !== 32'hDEADBEEF) $display("FAIL rd_data got=%h exp=deadbeef", d); else pass_cnt++;
  endtask

  task automatic test_byte_lanes();
    int l; logic a, e; logic [31:0] d;
    bus_xfer(0, 1, 32'h10, 32'h0000AA00, 4'b0010, l, a, e, d);
    total_cnt++; if (a !== 1'b1) $display("FAIL lane_wr_ack got=%b exp=1", a); else pass_cnt++;
    bus_xfer(0, 0, 32'h10, 32'h0, 4'b0001, l, a, e, d);
    total_cnt++; if (d !== 32'hDEADAAEF) $display("FAIL lane_rd got=%h exp=deadaaef", d); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (dat1 !== 32'h0) $display("FAIL dat_clear got=%h exp=0", dat1); else pass_cnt++;
    bus_xfer(0, 1, 32'h10, 32'hFFFFFFFF, 4'b0000, l, a, e, d);
    total_cnt++; if (a !== 1'b1 || e !== 1'b0) $display("FAIL sel0_ack got=%b%b exp=10", a, e); else pass_cnt++;
    bus_xfer(0, 0, 32'h10, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (d !== 32'hDEADAAEF) $display("FAIL sel0_rd got=%h exp=deadaaef", d); else pass_cnt++;
  endtask

  task automatic test_decode_err();
    int l; logic a, e; logic [31:0] d;
    bus_xfer(0, 0, 32'h100, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (l !== 2) $display("FAIL oor_latency got=%0d exp=2", l); else pass_cnt++;
    total_cnt++; if (e !== 1'b1 || a !== 1'b0) $display("FAIL oor_err got=ack%b err%b exp=ack0 err1", a, e); else pass_cnt++;
    total_cnt++; if (d !== 32'h0) $display("FAIL oor_dat got=%h exp=0", d); else pass_cnt++;
    bus_xfer(0, 0, 32'h12, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (l !== 2) $display("FAIL mis_latency got=%0d exp=2", l); else pass_cnt++;
    total_cnt++; if (e !== 1'b1 || a !== 1'b0) $display("FAIL mis_err got=ack%b err%b exp=ack0 err1", a, e); else pass_cnt++;
    total_cnt++; if (d !== 32'h0) $display("FAIL mis_dat got=%h exp=0", d); else pass_cnt++;
    // Misaligned write must not touch the aligned word
    bus_xfer(0, 1, 32'h12, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (e !== 1'b1) $display("FAIL mis_wr_err got=%b exp=1", e); else pass_cnt++;
    bus_xfer(0, 0, 32'h10, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (d !== 32'hDEADAAEF) $display("FAIL mis_wr_kept got=%h exp=deadaaef", d); else pass_cnt++;
    // Out-of-range write must not alias onto word 0
    bus_xfer(0, 1, 32'h0, 32'h11111111, 4'hF, l, a, e, d);
    bus_xfer(0, 1, 32'h100, 32'h99999999, 4'hF, l, a, e, d);
    total_cnt++; if (e !== 1'b1 || a !== 1'b0) $display("FAIL oor_wr_err got=ack%b err%b exp=ack0 err1", a, e); else pass_cnt++;
    bus_xfer(0, 0, 32'h0, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (d !== 32'h11111111) $display("FAIL no_alias got=%h exp=11111111", d); else pass_cnt++;
  endtask

  task automatic test_abort_and_latch();
    int l; logic a, e; logic [31:0] d; logic seen;
    bus_xfer(0, 1, 32'h20, 32'hCAFEF00D, 4'hF, l, a, e, d);
    // Start a write, then drop cyc during the wait state
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h20; wdat = 32'h12345678; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cyc = 0; stb = 0; we = 0;
    seen = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); @(negedge clk);
      if (ack1 || err1) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL abort_term got=%b exp=0", seen); else pass_cnt++;
    bus_xfer(0, 0, 32'h20, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (d !== 32'hCAFEF00D) $display("FAIL abort_nowrite got=%h exp=cafef00d", d); else pass_cnt++;
    // Bus changes during the wait state must not affect the accepted write
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h24; wdat = 32'hA5A5A5A5; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    we = 0; adr = 32'h28; wdat = 32'h0; sel = 4'h0;
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (ack1 !== 1'b1) $display("FAIL latch_ack got=%b exp=1", ack1); else pass_cnt++;
    cyc = 0; stb = 0;
    bus_xfer(0, 0, 32'h24, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (d !== 32'hA5A5A5A5) $display("FAIL latch_data got=%h exp=a5a5a5a5", d); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int l; logic a, e; logic [31:0] d;
    logic [4:1] hist;
    logic [4:1] exp_hist;
    exp_hist = 4'b0101;   // ACK in cycles N+1 and N+3 only
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h40; wdat = 32'h01010101; sel = 4'hF;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); @(negedge clk);
      hist[k] = ack0;
      if (k == 1) begin adr = 32'h44; wdat = 32'h02020202; end
      if (k == 3) begin cyc = 0; stb = 0; we = 0; end
    end
    total_cnt++; if (hist !== exp_hist) $display("FAIL b2b_ack_pattern got=%b exp=%b", hist, exp_hist); else pass_cnt++;
    bus_xfer(1, 0, 32'h40, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (l !== 1) $display("FAIL ws0_latency got=%0d exp=1", l); else pass_cnt++;
    total_cnt++; if (d !== 32'h01010101) $display("FAIL b2b_first got=%h exp=01010101", d); else pass_cnt++;
    bus_xfer(1, 0, 32'h44, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (d !== 32'h02020202) $display("FAIL b2b_second got=%h exp=02020202", d); else pass_cnt++;
  endtask

  task automatic test_reset_in_wait();
    int l; logic a, e; logic [31:0] d;
    bus_xfer(0, 1, 32'h30, 32'h0BADF00D, 4'hF, l, a, e, d);
    @(negedge clk);
    cyc = 1; stb = 1; we = 1; adr = 32'h30; wdat = 32'h55555555; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;   // cyc kept high: the reset edge would otherwise complete the write
    @(posedge clk);
    @(negedge clk);
    total_cnt++; if (ack1 !== 1'b0 || err1 !== 1'b0) $display("FAIL rst_wait_term got=ack%b err%b exp=ack0 err0", ack1, err1); else pass_cnt++;
    total_cnt++; if (dat1 !== 32'h0) $display("FAIL rst_wait_dat got=%h exp=0", dat1); else pass_cnt++;
    reset = 1'b0; cyc = 0; stb = 0; we = 0;
    bus_xfer(0, 0, 32'h30, 32'h0, 4'hF, l, a, e, d);
    total_cnt++; if (l !== 2) $display("FAIL rst_wait_idle got=%0d exp=2", l); else pass_cnt++;
    total_cnt++; if (d !== 32'h0BADF00D) $display("FAIL rst_wait_nowrite got=%h exp=0badf00d", d); else pass_cnt++;
  endtask

  // ack and err must never be asserted together on either responder
  always @(negedge clk) begin
    if (!reset && ((ack1 && err1) || (ack0 && err0))) begin
      total_cnt++;
      $display("FAIL ack_err_exclusive got=ack%b err%b ack0%b err0%b exp=not both", ack1, err1, ack0, err0);
    end
  end

  initial begin
    test_reset();
    test_full_word();
    test_byte_lanes();
    test_decode_err();
    test_abort_and_latch();
    test_back_to_back();
    test_reset_in_wait();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
